// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the bus-mapped interrupt controller: register map,
// FSM encoding and the ID register layout.
package irq_ctrl_pkg;

  localparam int unsigned NUM_IRQ_MAX = 8;
  localparam int unsigned NUM_REGS    = 5;
  localparam int unsigned BUS_W       = 8;
  localparam int unsigned SEL_W       = 3;

  localparam logic [7:0] OFF_PENDING = 8'd0;
  localparam logic [7:0] OFF_MASK    = 8'd1;
  localparam logic [7:0] OFF_MODE    = 8'd2;
  localparam logic [7:0] OFF_ACTIVE  = 8'd3;
  localparam logic [7:0] OFF_ID      = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAISE = 2'd1,
    ST_ACK   = 2'd2
  } irq_state_t;

  typedef struct packed {
    logic             valid;
    logic [3:0]       rsvd;
    logic [SEL_W-1:0] sel;
  } irq_id_t;

  // Offset of a bus address relative to the block base (wraps modulo 256).
  function automatic logic [7:0] reg_offset(input logic [7:0] addr, input logic [7:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports the lowest set request index.
module irq_priority_encoder
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid_c,
  output logic [SEL_W-1:0]   idx_c
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid_c = 1'b1;
        idx_c   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-channel event capture, software mask, fixed
// priority arbitration and a single raise/ack handshake towards the CPU.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 8,
  parameter logic [7:0]  BASE_ADDR  = 8'hE0,
  parameter logic [7:0]  MASK_RESET = 8'hFF,
  parameter logic [7:0]  MODE_RESET = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  inout  wire  [7:0]         bus_data,
  input  logic [7:0]         bus_addr,
  input  logic               bus_we,
  input  logic [NUM_IRQ-1:0] irq_raise,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               cpu_int_raise,
  input  logic               cpu_int_ack
);

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] mode;
  logic [NUM_IRQ-1:0] hist;
  irq_state_t         state;
  logic [SEL_W-1:0]   sel;
  logic [BUS_W-1:0]   rd_data;
  logic               rd_oe;

  logic [7:0]         offset_c;
  logic               hit_c;
  logic               wr_hit_c;
  logic               rd_hit_c;
  logic [NUM_IRQ-1:0] wdata_c;
  logic [NUM_IRQ-1:0] set_c;
  logic [NUM_IRQ-1:0] w1c_c;
  logic [NUM_IRQ-1:0] ack_clr_c;
  logic [NUM_IRQ-1:0] sel_onehot_c;
  logic [NUM_IRQ-1:0] req_c;
  logic               pend_valid_c;
  logic [SEL_W-1:0]   pend_idx_c;
  irq_id_t            id_c;
  logic [BUS_W-1:0]   rd_mux_c;

  // Address decode: only BASE..BASE+4 respond.
  assign offset_c = reg_offset(bus_addr, BASE_ADDR);
  assign hit_c    = offset_c < 8'(NUM_REGS);
  assign wr_hit_c = hit_c && bus_we;
  assign rd_hit_c = hit_c && !bus_we;
  assign wdata_c  = bus_data[NUM_IRQ-1:0];

  // Edge channels fire on a 0->1 sampled transition, level channels every high cycle.
  assign set_c        = irq_raise & ~(mode & hist);
  assign w1c_c        = (wr_hit_c && offset_c == OFF_PENDING) ? wdata_c : '0;
  assign sel_onehot_c = NUM_IRQ'(1) << sel;
  assign ack_clr_c    = (state == ST_ACK) ? sel_onehot_c : '0;
  assign req_c        = pending & mask;

  irq_priority_encoder #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .req     (req_c),
    .valid_c (pend_valid_c),
    .idx_c   (pend_idx_c)
  );

  // Event capture and software-visible configuration; a set always wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      hist    <= '0;
      mask    <= MASK_RESET[NUM_IRQ-1:0];
      mode    <= MODE_RESET[NUM_IRQ-1:0];
    end else begin
      pending <= (pending & ~(w1c_c | ack_clr_c)) | set_c;
      hist    <= irq_raise;
      if (wr_hit_c && offset_c == OFF_MASK) begin
        mask <= wdata_c;
      end
      if (wr_hit_c && offset_c == OFF_MODE) begin
        mode <= wdata_c;
      end
    end
  end

  // Service FSM; a latched channel is always carried through to its ack pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      sel           <= '0;
      cpu_int_raise <= 1'b0;
      irq_ack       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          irq_ack <= '0;
          if (pend_valid_c) begin
            sel           <= pend_idx_c;
            cpu_int_raise <= 1'b1;
            state         <= ST_RAISE;
          end
        end
        ST_RAISE: begin
          if (cpu_int_ack) begin
            cpu_int_raise <= 1'b0;
            irq_ack       <= sel_onehot_c;
            state         <= ST_ACK;
          end
        end
        ST_ACK: begin
          irq_ack       <= '0;
          cpu_int_raise <= 1'b0;
          state         <= ST_IDLE;
        end
        default: begin
          irq_ack       <= '0;
          cpu_int_raise <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    id_c       = '0;
    id_c.valid = (state != ST_IDLE);
    id_c.sel   = (state != ST_IDLE) ? sel : '0;
  end

  always_comb begin
    rd_mux_c = '0;
    case (offset_c)
      OFF_PENDING: rd_mux_c = BUS_W'(pending);
      OFF_MASK:    rd_mux_c = BUS_W'(mask);
      OFF_MODE:    rd_mux_c = BUS_W'(mode);
      OFF_ACTIVE:  rd_mux_c = (state != ST_IDLE) ? BUS_W'(sel_onehot_c) : '0;
      OFF_ID:      rd_mux_c = id_c;
      default:     rd_mux_c = '0;
    endcase
  end

  // Registered read data and output enable; the bus is released one cycle after the access ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_oe   <= 1'b0;
    end else begin
      rd_oe <= rd_hit_c;
      if (rd_hit_c) begin
        rd_data <= rd_mux_c;
      end
    end
  end

  assign bus_data = rd_oe ? rd_data : 8'bz;

endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised bus-mapped interrupt controller sitting between up to eight peripheral interrupt sources (mouse, timer, future blocks) and one CPU interrupt line, replacing direct wiring of peripheral raise/ack pairs onto the CPU interrupt bus. Latches per-channel events (edge or level mode), applies a software mask, and arbitrates fixed priority (lowest index wins). Presents one raise/ack handshake to the CPU and returns a one-cycle ack to the serviced source. Pending, mask, mode and active-channel state are visible on the shared 8-bit memory-mapped bus.

## Interface
- NUM_IRQ, 8, number of source channels, 1..8
- BASE_ADDR, 8'hE0, bus base address; occupies BASE_ADDR..BASE_ADDR+4
- MASK_RESET, 8'hFF, reset value of MASK (bit set = enabled)
- MODE_RESET, 8'h00, reset value of MODE (bit set = edge, clear = level)

- CLK  in  1  system clock; all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- BUS_DATA  inout  8  shared data bus; driven only during an addressed read
- BUS_ADDR  in  8  shared address bus
- BUS_WE  in  1  bus write enable
- IRQ_RAISE  in  NUM_IRQ  source raise lines
- IRQ_ACK  out  NUM_IRQ  one-cycle ack pulse to the serviced source
- CPU_INT_RAISE  out  1  to one CPU interrupt raise input
- CPU_INT_ACK  in  1  from the matching CPU interrupt ack output

## Operation
- Register map; bits above NUM_IRQ-1 read 0 and ignore writes:
  - +0 PENDING: R; write 1 to clear
  - +1 MASK: R/W
  - +2 MODE: R/W
  - +3 ACTIVE: R; one-hot of the channel in service, 0 when IDLE
  - +4 ID: R; {valid, 4'b0, sel[2:0]}
  - +5..+7: not decoded; BUS_DATA stays high-Z
- Event capture per channel:
  - Edge mode: raise sampled 1 after being sampled 0 sets PENDING.
  - Level mode: raise sampled 1 sets PENDING every cycle.
  - Set beats any same-cycle clear (software W1C or ack clear), so no event is lost.
- FSM states: IDLE, RAISE, ACK.
  - IDLE: if (PENDING & MASK) != 0, latch sel = lowest set index and go to RAISE.
  - RAISE: CPU_INT_RAISE = 1; hold until CPU_INT_ACK = 1, then go to ACK.
  - ACK: IRQ_ACK[sel] = 1 for exactly one cycle; clear PENDING[sel]; CPU_INT_RAISE = 0; go to IDLE.
- Once latched in RAISE, never withdrawn: masking or W1C of sel does not cancel it, and the IRQ_ACK pulse still occurs.
- CPU_INT_ACK outside RAISE is ignored.
- Level sources must drop raise on IRQ_ACK. If raise is still high, PENDING re-sets and the channel is re-raised.
- Reset (async, any state): FSM to IDLE; PENDING = 0; edge history = 0; MASK = MASK_RESET; MODE = MODE_RESET; IRQ_ACK = 0; CPU_INT_RAISE = 0; BUS_DATA released.

## Timing
- Raise sampled at edge n: PENDING set after edge n; FSM enters RAISE after edge n+1; CPU_INT_RAISE high from edge n+1 (2-cycle latency).
- CPU_INT_ACK sampled at edge m: IRQ_ACK[sel] high for cycle m..m+1; earliest re-raise of another pending channel after edge m+2.
- Writes: take effect at the edge where BUS_WE = 1 and address matches.
- Reads: address presented with BUS_WE = 0 at edge k; data is registered, and output-enable is registered, so BUS_DATA is driven k..k+1. Releases the cycle after the address leaves the range or BUS_WE rises.
- Back-to-back: with ch0 and ch3 pending, ch0 is serviced first; ch3 is raised 2 cycles after ch0's ack.

## Structure
- Package irq_ctrl_pkg: register offsets (OFF_PENDING..OFF_ID), FSM state encoding, NUM_IRQ_MAX = 8.
- Sub-module irq_priority_encoder: combinational, NUM_IRQ-wide request in; valid plus 3-bit index out, lowest index first.
- All state registers, bus decode and tri-state driver live in irq_controller.

## Test plan
- Reset defaults: after RESET low then high, read +1 = 8'hFF, +2 = 8'h00, +0 = 8'h00; CPU_INT_RAISE = 0 and IRQ_ACK = 0.
- Single level source: IRQ_RAISE[0] high at edge n → CPU_INT_RAISE high from n+1; CPU ack pulse at edge m → IRQ_ACK = 8'h01 for one cycle; PENDING[0] cleared.
- Priority: IRQ_RAISE = 8'b0000_1010 in one cycle → ID reads 8'h81 (ch1) first; after ack, ID reads 8'h83 (ch3).
- Mask and edge: write MODE = 8'h04 and MASK = 8'hFB; pulse IRQ_RAISE[2] for one cycle → PENDING = 8'h04, no CPU_INT_RAISE. Write MASK = 8'hFF → raise follows 1 cycle later.
- Set/clear collision: edge on ch2 coincides with W1C write 8'h04 to +0 → PENDING[2] stays 1.
- Reset mid-service: assert RESET in RAISE state → CPU_INT_RAISE drops asynchronously; after release, the FSM is in IDLE and PENDING = 0.
